de2i150_core_status_port: RTL and testbench

Avalon-MM slave input port: the read-back path for accelerator status, complementing the 32-bit command output port on the same core. It samples a 32-bit `in_port` from the accelerator fabric through a two-stage synchronizer and exposes the synchronized value to the host. It latches per-bit edges into a sticky capture register and raises a maskable level interrupt. Sits on the core's Avalon bus at its own base address, next to the command port.

---
 rtl/de2i150_core_pio_pkg.sv | 28 ++
 rtl/de2i150_core_sync_edge.sv | 51 +++++
 rtl/de2i150_core_status_port.sv | 85 ++++++++
 tb/tb_de2i150_core_status_port.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/de2i150_core_pio_pkg.sv
// Shared constants and helpers for the core's Avalon-MM PIO blocks.
// Register word addresses, edge-capture modes and the edge-term rule.
package de2i150_core_pio_pkg;

  localparam logic [1:0] ADDR_DATA    = 2'd0;
  localparam logic [1:0] ADDR_IRQMASK = 2'd1;
  localparam logic [1:0] ADDR_RSVD    = 2'd2;
  localparam logic [1:0] ADDR_EDGECAP = 2'd3;

  localparam int EDGE_RISE = 0;
  localparam int EDGE_FALL = 1;
  localparam int EDGE_ANY  = 2;

  // Per-bit edge term from the current and previous synchronized samples.
  function automatic logic [31:0] edge_term(input int edge_type,
                                            input logic [31:0] cur,
                                            input logic [31:0] prv);
    logic [31:0] res;
    case (edge_type)
      EDGE_RISE: res = cur & ~prv;
      EDGE_FALL: res = ~cur & prv;
      EDGE_ANY:  res = cur ^ prv;
      default:   res = cur & ~prv;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/de2i150_core_sync_edge.sv
// Two-stage synchronizer plus edge detector for asynchronous status inputs.
// Edges are held off until the pipeline has flushed its reset zeros.
module de2i150_core_sync_edge
  import de2i150_core_pio_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int EDGE_TYPE = EDGE_RISE
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] i_in,
  output logic [WIDTH-1:0] o_sync,
  output logic [WIDTH-1:0] o_edge
);

  logic [WIDTH-1:0] r_sync1;
  logic [WIDTH-1:0] r_sync2;
  logic [WIDTH-1:0] r_prev;
  logic [1:0]       r_warm;
  logic [31:0]      w_edge_full;

  // Synchronizer, previous-sample stage and saturating warm-up counter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync1 <= {WIDTH{1'b0}};
      r_sync2 <= {WIDTH{1'b0}};
      r_prev  <= {WIDTH{1'b0}};
      r_warm  <= 2'd0;
    end else begin
      r_sync1 <= i_in;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
      if (r_warm != 2'd3) begin
        r_warm <= r_warm + 2'd1;
      end
    end
  end

  // Edge term, gated to zero while the warm-up count is below 3.
  always_comb begin
    w_edge_full = edge_term(EDGE_TYPE, 32'(r_sync2), 32'(r_prev));
    if (r_warm == 2'd3) begin
      o_edge = w_edge_full[WIDTH-1:0];
    end else begin
      o_edge = {WIDTH{1'b0}};
    end
  end

  assign o_sync = r_sync2;

endmodule

// File: rtl/de2i150_core_status_port.sv
// Avalon-MM status input port: synchronized DATA, IRQMASK, sticky EDGECAPTURE
// with write-1-to-clear, registered read data and a level interrupt.
module de2i150_core_status_port
  import de2i150_core_pio_pkg::*;
#(
  parameter int EDGE_TYPE = EDGE_RISE,
  parameter int WIDTH     = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             read_n,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  logic [WIDTH-1:0] w_sync;
  logic [WIDTH-1:0] w_edge;
  logic [WIDTH-1:0] w_clr;
  logic [31:0]      w_rdmux;
  logic             w_wr;
  logic             w_rd;
  logic [WIDTH-1:0] r_irqmask;
  logic [WIDTH-1:0] r_edgecap;
  logic [31:0]      r_readdata;

  de2i150_core_sync_edge #(
    .WIDTH     (WIDTH),
    .EDGE_TYPE (EDGE_TYPE)
  ) u_sync_edge (
    .clk     (clk),
    .reset_n (reset_n),
    .i_in    (in_port),
    .o_sync  (w_sync),
    .o_edge  (w_edge)
  );

  assign w_wr = chipselect & ~write_n;
  assign w_rd = chipselect & ~read_n;

  // Write-1-to-clear vector for EDGECAPTURE.
  always_comb begin
    if (w_wr && (address == ADDR_EDGECAP)) begin
      w_clr = writedata[WIDTH-1:0];
    end else begin
      w_clr = {WIDTH{1'b0}};
    end
  end

  // Read mux; bits above WIDTH and the reserved word read as zero.
  always_comb begin
    w_rdmux = 32'h0000_0000;
    case (address)
      ADDR_DATA:    w_rdmux[WIDTH-1:0] = w_sync;
      ADDR_IRQMASK: w_rdmux[WIDTH-1:0] = r_irqmask;
      ADDR_EDGECAP: w_rdmux[WIDTH-1:0] = r_edgecap;
      default:      w_rdmux = 32'h0000_0000;
    endcase
  end

  // Register file; a new edge overrides a same-cycle clear of that bit.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_irqmask  <= {WIDTH{1'b0}};
      r_edgecap  <= {WIDTH{1'b0}};
      r_readdata <= 32'h0000_0000;
    end else begin
      if (w_wr && (address == ADDR_IRQMASK)) begin
        r_irqmask <= writedata[WIDTH-1:0];
      end
      r_edgecap <= (r_edgecap & ~w_clr) | w_edge;
      if (w_rd) begin
        r_readdata <= w_rdmux;
      end
    end
  end

  assign readdata = r_readdata;
  assign irq      = |(r_edgecap & r_irqmask);

endmodule

// File: tb/tb_de2i150_core_status_port.sv
// Bench for de2i150_core_status_port: rising-edge and any-edge instances
// compared every cycle against a delay-line reference of the register map.
module tb_de2i150_core_status_port;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [1:0]  address = 2'd0;
  logic        chipselect = 1'b0;
  logic        read_n = 1'b1;
  logic        write_n = 1'b1;
  logic [31:0] writedata = 32'h0;
  logic [31:0] in_port = 32'h0;
  logic [31:0] readdata0;
  logic [31:0] readdata2;
  logic        irq0;
  logic        irq2;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  de2i150_core_status_port #(.EDGE_TYPE(0), .WIDTH(32)) dut0 (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .read_n(read_n), .write_n(write_n), .writedata(writedata),
    .in_port(in_port), .readdata(readdata0), .irq(irq0)
  );

  de2i150_core_status_port #(.EDGE_TYPE(2), .WIDTH(32)) dut2 (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .read_n(read_n), .write_n(write_n), .writedata(writedata),
    .in_port(in_port), .readdata(readdata2), .irq(irq2)
  );

  // Reference: in_port samples per clock since reset; DATA is the sample
  // two clocks back, edges compare samples two and three clocks back.
  logic [31:0] m_hist[$];
  int          m_n;
  logic [31:0] m_cap[2];
  logic [31:0] m_mask[2];
  logic [31:0] m_rd[2];

  function automatic logic [31:0] in_at(int m);
    if (m <= 0) return 32'h0;
    return m_hist[m-1];
  endfunction

  task automatic model_reset();
    m_n = 0;
    m_hist.delete();
    for (int i = 0; i < 2; i++) begin
      m_cap[i] = 32'h0; m_mask[i] = 32'h0; m_rd[i] = 32'h0;
    end
  endtask

  task automatic model_edge();
    logic [31:0] cur, old, e, clr;
    m_n = m_n + 1;
    m_hist.push_back(in_port);
    cur = in_at(m_n - 2);
    old = in_at(m_n - 3);
    clr = (chipselect && !write_n && address == 2'd3) ? writedata : 32'h0;
    for (int i = 0; i < 2; i++) begin
      e = (i == 0) ? (cur & ~old) : (cur ^ old);
      if (m_n < 4) e = 32'h0;
      if (chipselect && !read_n) begin
        case (address)
          2'd0: m_rd[i] = cur;
          2'd1: m_rd[i] = m_mask[i];
          2'd3: m_rd[i] = m_cap[i];
          default: m_rd[i] = 32'h0;
        endcase
      end
      m_cap[i] = (m_cap[i] & ~clr) | e;
      if (chipselect && !write_n && address == 2'd1) m_mask[i] = writedata;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_all();
    chk("rd_rise", readdata0, m_rd[0]);
    chk("irq_rise", {31'b0, irq0}, {31'b0, |(m_cap[0] & m_mask[0])});
    chk("rd_any", readdata2, m_rd[1]);
    chk("irq_any", {31'b0, irq2}, {31'b0, |(m_cap[1] & m_mask[1])});
  endtask

  task automatic step();
    @(posedge clk);
    if (reset_n) model_edge();
    #1;
  endtask

  task automatic cyc(input logic cs, input logic rdn, input logic wrn,
                     input logic [1:0] a, input logic [31:0] d);
    chipselect = cs; read_n = rdn; write_n = wrn; address = a; writedata = d;
    step();
    chk_all();
    chipselect = 1'b0; read_n = 1'b1; write_n = 1'b1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b1, 1'b1, 2'd0, 32'h0);
  endtask

  task automatic rd(input logic [1:0] a);
    cyc(1'b1, 1'b0, 1'b1, a, 32'h0);
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    cyc(1'b1, 1'b1, 1'b0, a, d);
  endtask

  task automatic rand_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(0, 3) == 0) in_port = in_port ^ (32'h1 << $urandom_range(0, 31));
      cyc($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
          2'($urandom_range(0, 3)),
          ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom());
    end
  endtask

  initial begin
    // Reset with all inputs high; warm-up must hide the pipeline's 0->1 edge.
    model_reset();
    in_port = 32'hFFFF_FFFF;
    step(); step();
    chk("reset_rd", readdata0, 32'h0);
    chk("reset_irq", {31'b0, irq0}, 32'h0);
    reset_n = 1'b1;
    idle(3);
    rd(2'd3);
    chk("warmup_cap_rise", readdata0, 32'h0);
    chk("warmup_cap_any", readdata2, 32'h0);
    rd(2'd0);
    chk("data_ones", readdata0, 32'hFFFF_FFFF);

    // Rising edge on bit 0 with mask 1, then W1C.
    in_port = 32'h0;
    idle(4);
    wr(2'd3, 32'hFFFF_FFFF);
    wr(2'd1, 32'h0000_0001);
    in_port = 32'h0000_0001;
    idle(2);
    chk("irq_before_k2", {31'b0, irq0}, 32'h0);
    rd(2'd3);
    chk("irq_at_k2", {31'b0, irq0}, 32'h1);
    chk("cap_pre_update", readdata0, 32'h0);
    rd(2'd3);
    chk("cap_bit0", readdata0, 32'h0000_0001);
    wr(2'd3, 32'h0000_0001);
    chk("irq_w1c", {31'b0, irq0}, 32'h0);

    // W1C on the same edge as a new bit-3 capture: edge wins.
    wr(2'd1, 32'h0000_0008);
    in_port = 32'h0000_0009;
    idle(2);
    wr(2'd3, 32'h0000_0008);
    chk("edge_beats_w1c_irq", {31'b0, irq0}, 32'h1);
    rd(2'd3);
    chk("edge_beats_w1c_cap", readdata0, 32'h0000_0008);

    // Bit 5 captured while masked out, then unmasked.
    wr(2'd1, 32'h0);
    wr(2'd3, 32'hFFFF_FFFF);
    in_port = 32'h0000_0029;
    idle(3);
    chk("masked_irq", {31'b0, irq0}, 32'h0);
    rd(2'd3);
    chk("masked_cap", readdata0, 32'h0000_0020);
    wr(2'd1, 32'h0000_0020);
    chk("unmask_irq", {31'b0, irq0}, 32'h1);

    // Any-edge instance: bit 7 toggles, re-armed by W1C between toggles.
    wr(2'd3, 32'hFFFF_FFFF);
    for (int t = 0; t < 3; t++) begin
      in_port = in_port ^ 32'h0000_0080;
      idle(4);
      rd(2'd3);
      chk("any_bit7", readdata2, 32'h0000_0080);
      wr(2'd3, 32'h0000_0080);
    end

    // Back-to-back reads of every address.
    rd(2'd0); rd(2'd1); rd(2'd2);
    chk("rsvd_zero", readdata0, 32'h0);
    rd(2'd3);

    rand_cycles(400);

    // Asynchronous reset mid-operation, then warm-up again.
    #2;
    reset_n = 1'b0;
    #1;
    model_reset();
    chk("async_rd_rise", readdata0, 32'h0);
    chk("async_irq_rise", {31'b0, irq0}, 32'h0);
    chk("async_rd_any", readdata2, 32'h0);
    chk("async_irq_any", {31'b0, irq2}, 32'h0);
    in_port = $urandom();
    step(); step();
    reset_n = 1'b1;
    rand_cycles(150);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
